// File: rtl/id_writer_pkg.sv
// Shared constants and state encoding for the run-time loadable ID store.
package id_writer_pkg;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned DATA_W  = 4;
    localparam int unsigned BCD_MAX = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

endpackage

// File: rtl/id_writer_if.sv
// Digit stream into the ID writer: valid/ready handshake carrying one digit.
interface id_writer_if #(
    parameter int unsigned DATA_W = id_writer_pkg::DATA_W
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/id_writer_ram.sv
// DEPTH x DATA_W register file: one synchronous write port, one combinational read port.
module id_ram #(
    parameter int unsigned DEPTH  = id_writer_pkg::DEPTH,
    parameter int unsigned ADDR_W = id_writer_pkg::ADDR_W,
    parameter int unsigned DATA_W = id_writer_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: cleared on reset, written one word per cycle when we is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port has no latency; a same-cycle write shows up after the edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/id_writer.sv
// Write side of the ID store: loads digits from a stream into id_ram and
// serves the display read port directly from the register file.
module id_writer
    import id_writer_pkg::*;
#(
    parameter int unsigned DEPTH     = id_writer_pkg::DEPTH,
    parameter int unsigned ADDR_W    = id_writer_pkg::ADDR_W,
    parameter int unsigned DATA_W    = id_writer_pkg::DATA_W,
    parameter bit          CHECK_BCD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_abort,
    id_writer_if.slave        stream,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] id
);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              transfer;
    logic              digit_ok;
    logic              we;

    // in_ready is the registered busy flag, so a transfer implies state LOAD.
    assign stream.in_ready = busy;
    assign transfer        = stream.in_valid & busy;
    assign digit_ok        = !CHECK_BCD || (stream.in_data <= DATA_W'(BCD_MAX));
    assign we              = transfer & digit_ok & ~load_start & ~load_abort;

    // Load sequencer: state, write pointer, sticky error and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_start) begin
                        state  <= LOAD;
                        wr_ptr <= '0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wr_ptr <= '0;
                        err    <= 1'b0;
                    end else if (load_abort) begin
                        state  <= IDLE;
                        wr_ptr <= '0;
                        busy   <= 1'b0;
                    end else if (transfer) begin
                        if (!digit_ok) begin
                            err <= 1'b1;
                        end else if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
                            state  <= DONE;
                            wr_ptr <= '0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    wr_ptr <= '0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

    id_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (stream.in_data),
        .raddr (addr),
        .rdata (id)
    );

endmodule

// File: tb/tb_id_writer.sv
// Bench for id_writer: one instance with BCD checking, one without, fed the
// same stream; accepted digits go into per-instance write queues that are
// folded into expected images and compared against the read port.
module tb_id_writer;

    typedef struct {
        logic [2:0] a;
        logic [3:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic       load_abort = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] data = '0;
    logic [2:0] addr = '0;
    logic       busy1, done1, err1, busy0, done0, err0;
    logic [3:0] id1, id0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    wr_t        q1[$];
    wr_t        q0[$];
    logic [3:0] img1 [8];
    logic [3:0] img0 [8];
    logic [2:0] ptr1 = '0;
    logic [2:0] ptr0 = '0;
    logic       exp_err1 = 1'b0;

    id_writer_if #(.DATA_W(4)) if1 ();
    id_writer_if #(.DATA_W(4)) if0 ();

    assign if1.in_valid = valid;
    assign if1.in_data  = data;
    assign if0.in_valid = valid;
    assign if0.in_data  = data;

    id_writer #(.CHECK_BCD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
        .stream(if1), .busy(busy1), .done(done1), .err(err1), .addr(addr), .id(id1)
    );

    id_writer #(.CHECK_BCD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_abort(load_abort),
        .stream(if0), .busy(busy0), .done(done0), .err(err0), .addr(addr), .id(id0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_model();
        q1.delete();
        q0.delete();
        for (int unsigned i = 0; i < 8; i++) begin
            img1[i] = '0;
            img0[i] = '0;
        end
        ptr1     = '0;
        ptr0     = '0;
        exp_err1 = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic b, input logic d);
        check({tag, "_busy"}, busy1, b);
        check({tag, "_ready"}, if1.in_ready, b);
        check({tag, "_done"}, done1, d);
        check({tag, "_busy0"}, busy0, b);
        check({tag, "_done0"}, done0, d);
    endtask

    // Pulse load_start (optionally with load_abort) for one cycle.
    task automatic start_pulse(input logic with_abort);
        load_start = 1'b1;
        load_abort = with_abort;
        tick();
        load_start = 1'b0;
        load_abort = 1'b0;
        ptr1 = '0;
        ptr0 = '0;
        exp_err1 = 1'b0;
    endtask

    task automatic abort_pulse();
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        ptr1 = '0;
        ptr0 = '0;
    endtask

    // Offer one digit after `gap` idle cycles; waits (bounded) for acceptance.
    task automatic send(input logic [3:0] d, input int unsigned gap);
        logic r;
        logic ok;
        ok = 1'b0;
        for (int unsigned g = 0; g < gap; g++) begin
            valid = 1'b0;
            data  = 4'($urandom);
            tick();
        end
        valid = 1'b1;
        data  = d;
        for (int unsigned n = 0; n < 20; n++) begin
            r = if1.in_ready;
            tick();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        valid = 1'b0;
        check("send_accept", {31'd0, ok}, 32'd1);
        if (ok) begin
            if (d <= 4'd9) begin
                q1.push_back('{a: ptr1, d: d});
                ptr1 = ptr1 + 3'd1;
            end else begin
                exp_err1 = 1'b1;
            end
            q0.push_back('{a: ptr0, d: d});
            ptr0 = ptr0 + 3'd1;
        end
    endtask

    // Retire queued writes into the expected images and sweep the read port.
    task automatic verify_image(input string tag);
        wr_t e;
        while (q1.size() > 0) begin
            e = q1.pop_front();
            img1[e.a] = e.d;
        end
        while (q0.size() > 0) begin
            e = q0.pop_front();
            img0[e.a] = e.d;
        end
        for (int unsigned a = 0; a < 8; a++) begin
            addr = 3'(a);
            #1;
            check({tag, "_id1"}, {28'd0, id1}, {28'd0, img1[a]});
            check({tag, "_id0"}, {28'd0, id0}, {28'd0, img0[a]});
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] seq2 [8];
        logic [3:0] seq3 [8];
        seq2 = '{4'd1, 4'd9, 4'd0, 4'd0, 4'd1, 4'd6, 4'd2, 4'd1};
        seq3 = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};
        clear_model();

        // Power-on reset.
        tick();
        tick();
        check_status("por", 1'b0, 1'b0);
        check("por_err", err1, 1'b0);
        verify_image("por");
        rst_n = 1'b1;
        tick();

        // 1: reset in the middle of a load, asserted between clock edges.
        start_pulse(1'b0);
        send(4'd3, 0);
        send(4'd4, 0);
        send(4'd5, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_status("rst_mid", 1'b0, 1'b0);
        check("rst_mid_err", err1, 1'b0);
        clear_model();
        verify_image("rst_mid");
        rst_n = 1'b1;
        tick();

        // 2: full load with in_valid held high, one transfer per cycle.
        start_pulse(1'b0);
        check_status("load_go", 1'b1, 1'b0);
        for (int unsigned i = 0; i < 8; i++) begin
            check("full_ready", if1.in_ready, 1'b1);
            send(seq2[i], 0);
        end
        check_status("full_done", 1'b0, 1'b1);
        verify_image("full");

        // 3: valid in DONE writes nothing, then a load with random gaps.
        valid = 1'b1;
        data  = 4'd7;
        for (int unsigned i = 0; i < 3; i++) tick();
        valid = 1'b0;
        check_status("done_hold", 1'b0, 1'b1);
        verify_image("done_frozen");
        start_pulse(1'b0);
        for (int unsigned i = 0; i < 8; i++) send(seq3[i], $urandom_range(0, 2));
        check_status("gaps_done", 1'b0, 1'b1);
        verify_image("gaps");

        // 4: BCD rejection on one instance, pass-through on the other.
        start_pulse(1'b0);
        send(4'd3, 0);
        send(4'hA, 1);
        send(4'd4, 0);
        check("bcd_err1", err1, exp_err1);
        check("bcd_err0", err0, 1'b0);
        check("bcd_busy", busy1, 1'b1);
        verify_image("bcd");
        abort_pulse();
        check("bcd_err_abort", err1, 1'b1);
        check_status("bcd_abort", 1'b0, 1'b0);
        start_pulse(1'b0);
        check("bcd_err_clr", err1, 1'b0);

        // 5: restart with concurrent digit, abort, and start+abort together.
        send(4'd1, 0);
        send(4'd2, 0);
        send(4'd3, 0);
        send(4'd4, 0);
        valid = 1'b1;
        data  = 4'd9;
        start_pulse(1'b0);
        valid = 1'b0;
        send(4'd5, 0);
        send(4'd6, 0);
        valid = 1'b1;
        data  = 4'd7;
        abort_pulse();
        check_status("abort", 1'b0, 1'b0);
        data = 4'd8;
        tick();
        tick();
        valid = 1'b0;
        verify_image("abort");
        start_pulse(1'b1);
        check_status("both_idle", 1'b1, 1'b0);
        send(4'd2, 0);
        send(4'd2, 0);
        start_pulse(1'b1);
        check_status("both_load", 1'b1, 1'b0);
        send(4'd1, 0);
        send(4'd1, 0);
        send(4'd5, 0);
        verify_image("pre_coll");

        // 6: read/write collision at address 2.
        start_pulse(1'b0);
        send(4'd4, 0);
        send(4'd4, 0);
        addr  = 3'd2;
        valid = 1'b1;
        data  = 4'd7;
        #1;
        check("coll_before", {28'd0, id1}, 32'd5);
        check("coll_ready", if1.in_ready, 1'b1);
        tick();
        valid = 1'b0;
        check("coll_after", {28'd0, id1}, 32'd7);
        q1.push_back('{a: ptr1, d: 4'd7});
        q0.push_back('{a: ptr0, d: 4'd7});
        ptr1 = ptr1 + 3'd1;
        ptr0 = ptr0 + 3'd1;
        send(4'd0, 0);
        send(4'd1, 0);
        send(4'd2, 0);
        send(4'd3, 0);
        send(4'd9, 0);
        check_status("coll_done", 1'b0, 1'b1);
        verify_image("coll");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
